// File: rtl/hamming_window_mul_pipe.sv
// Pipelined scaled multiplier: extend, multiply, round, shift, saturate.
// Ports: clk, reset, ce, din_valid, din0, din1 -> dout_valid, dout, ovf; clr_ovf.
module hamming_window_mul_pipe #(
  parameter int DIN0_WIDTH  = 14,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 3,
  parameter int SHIFT       = 14,
  parameter int ROUND       = 1,
  parameter int SAT         = 1,
  parameter int DOUT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         din_valid,
  input  logic [DIN0_WIDTH-1:0]        din0,
  input  logic [DIN1_WIDTH-1:0]        din1,
  output logic                         dout_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf,
  input  logic                         clr_ovf
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int EW  = (PW + 1 > DOUT_WIDTH + 1) ?
                       PW + 1 : DOUT_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] RADD =
    (ROUND != 0 && SHIFT > 0) ? (ONE << RSH) : '0;
  localparam logic signed [EW-1:0] MAXV =
    (ONE << (DOUT_WIDTH - 1)) - ONE;
  localparam logic signed [EW-1:0] MINV =
    -(ONE << (DOUT_WIDTH - 1));

  function automatic logic signed [DIN0_WIDTH:0] ext0(
    input logic [DIN0_WIDTH-1:0] v
  );
    ext0 = (DIN0_SIGNED != 0) ? {v[DIN0_WIDTH-1], v} : {1'b0, v};
  endfunction

  function automatic logic signed [DIN1_WIDTH:0] ext1(
    input logic [DIN1_WIDTH-1:0] v
  );
    ext1 = (DIN1_SIGNED != 0) ? {v[DIN1_WIDTH-1], v} : {1'b0, v};
  endfunction

  function automatic logic signed [PW-1:0] mul(
    input logic signed [DIN0_WIDTH:0] a,
    input logic signed [DIN1_WIDTH:0] b
  );
    mul = a * b;
  endfunction

  logic signed [PW-1:0] fin_prod;
  logic                 fin_vld;

  // Stage 1 registers the extended operands, the multiply lands in
  // stage 2, extra stages delay the product, and the last stage
  // does round/shift/saturate into the output registers.
  generate
    if (NUM_STAGE == 1) begin : g_s1
      assign fin_prod = mul(ext0(din0), ext1(din1));
      assign fin_vld  = din_valid;
    end else begin : g_sn
      logic signed [DIN0_WIDTH:0] a0_q;
      logic signed [DIN1_WIDTH:0] a1_q;
      logic                       v1_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          v1_q <= 1'b0;
        end else if (ce) begin
          v1_q <= din_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (ce) begin
          a0_q <= ext0(din0);
          a1_q <= ext1(din1);
        end
      end

      if (NUM_STAGE == 2) begin : g_s2
        assign fin_prod = mul(a0_q, a1_q);
        assign fin_vld  = v1_q;
      end else begin : g_s3
        localparam int ND = NUM_STAGE - 2;
        logic signed [PW-1:0] p_q [ND];
        logic [ND-1:0]        pv_q;

        always_ff @(posedge clk) begin
          if (reset) begin
            pv_q <= '0;
          end else if (ce) begin
            pv_q[0] <= v1_q;
            for (int i = 1; i < ND; i++) begin
              pv_q[i] <= pv_q[i-1];
            end
          end
        end

        always_ff @(posedge clk) begin
          if (ce) begin
            p_q[0] <= mul(a0_q, a1_q);
            for (int i = 1; i < ND; i++) begin
              p_q[i] <= p_q[i-1];
            end
          end
        end

        assign fin_prod = p_q[ND-1];
        assign fin_vld  = pv_q[ND-1];
      end
    end
  endgenerate

  logic signed [EW-1:0]         pe;
  logic signed [EW-1:0]         rnd;
  logic signed [EW-1:0]         shv;
  logic                         hi_c;
  logic                         lo_c;
  logic                         ovf_c;
  logic signed [DOUT_WIDTH-1:0] res;

  always_comb begin
    pe    = {{(EW-PW){fin_prod[PW-1]}}, fin_prod};
    rnd   = pe + RADD;
    shv   = rnd >>> SHIFT;
    hi_c  = shv > MAXV;
    lo_c  = shv < MINV;
    ovf_c = hi_c || lo_c;
    res   = shv[DOUT_WIDTH-1:0];
    if (SAT != 0 && hi_c) begin
      res = MAXV[DOUT_WIDTH-1:0];
    end else if (SAT != 0 && lo_c) begin
      res = MINV[DOUT_WIDTH-1:0];
    end
  end

  logic                         dv_q;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         ovf_q;
  logic                         ovf_d;

  // Sticky flag: a new overflow beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ce && fin_vld && ovf_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dv_q   <= 1'b0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (ce) begin
        dv_q <= fin_vld;
        if (fin_vld) begin
          dout_q <= res;
        end
      end
    end
  end

  assign dout_valid = dv_q;
  assign dout       = dout_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_hamming_window_mul_pipe.sv
// Bench for hamming_window_mul_pipe: four parameter variants, table,
// directed corner sequences and a random run against a reference model.
module tb_hamming_window_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ce;
  logic        din_valid;
  logic        clr_ovf;
  logic [13:0] din0;
  logic [15:0] din1;

  logic        dv_a   [4];
  logic [15:0] dout_a [4];
  logic        ovf_a  [4];

  hamming_window_mul_pipe #(.SHIFT(14), .ROUND(1), .SAT(1)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1), .dout_valid(dv_a[0]),
    .dout(dout_a[0]), .ovf(ovf_a[0]), .clr_ovf(clr_ovf));

  hamming_window_mul_pipe #(.SHIFT(14), .ROUND(0), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1), .dout_valid(dv_a[1]),
    .dout(dout_a[1]), .ovf(ovf_a[1]), .clr_ovf(clr_ovf));

  hamming_window_mul_pipe #(.SHIFT(12), .ROUND(1), .SAT(1)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1), .dout_valid(dv_a[2]),
    .dout(dout_a[2]), .ovf(ovf_a[2]), .clr_ovf(clr_ovf));

  hamming_window_mul_pipe #(.SHIFT(14), .ROUND(1), .SAT(0)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1), .dout_valid(dv_a[3]),
    .dout(dout_a[3]), .ovf(ovf_a[3]), .clr_ovf(clr_ovf));

  int SH [4] = '{14, 14, 12, 14};
  bit RN [4] = '{1, 0, 1, 1};
  bit ST [4] = '{1, 1, 1, 0};

  typedef struct packed {
    logic [31:0]       due;
    logic [3:0][15:0]  d;
    logic [3:0]        o;
  } exp_t;

  typedef struct {
    logic [13:0] a;
    logic [15:0] b;
    logic [15:0] x0;
    logic [15:0] x1;
  } vec_t;

  exp_t        q[$];
  logic [31:0] cnt;
  logic        ev;
  logic [15:0] ed [4];
  logic        eo [4];
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void mdl(input logic [13:0] a,
                              input logic [15:0] b,
                              input int sh, input bit rn, input bit st,
                              output logic [15:0] d, output logic o);
    longint p;
    p = longint'(a) * longint'($signed(b));
    if (rn && sh > 0) p = p + (longint'(1) <<< (sh - 1));
    p = p >>> sh;
    o = (p > 32767) || (p < -32768);
    if (st && p > 32767) d = 16'h7fff;
    else if (st && p < -32768) d = 16'h8000;
    else d = p[15:0];
  endfunction

  task automatic step();
    exp_t        e;
    bit          hit;
    logic [15:0] dd;
    logic        oo;
    @(posedge clk);
    hit = 0;
    e   = '0;
    if (reset) begin
      q.delete();
      ev = 0;
      for (int i = 0; i < 4; i++) begin
        ed[i] = '0;
        eo[i] = 0;
      end
    end else begin
      if (ce) begin
        cnt++;
        if (din_valid) begin
          e.due = cnt + 2;
          for (int i = 0; i < 4; i++) begin
            mdl(din0, din1, SH[i], RN[i], ST[i], dd, oo);
            e.d[i] = dd;
            e.o[i] = oo;
          end
          q.push_back(e);
        end
        if (q.size() > 0 && q[0].due == cnt) begin
          e   = q.pop_front();
          hit = 1;
          for (int i = 0; i < 4; i++) ed[i] = e.d[i];
        end
        ev = hit;
      end
      for (int i = 0; i < 4; i++) begin
        if (hit && e.o[i]) eo[i] = 1;
        else if (clr_ovf) eo[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_dv%0d", i), dv_a[i], ev);
      chk($sformatf("sb_dout%0d", i), dout_a[i], ed[i]);
      chk($sformatf("sb_ovf%0d", i), ovf_a[i], eo[i]);
    end
  endtask

  vec_t        tbl [7];
  int          vcount;
  logic [12:0] pat;

  initial begin
    checks = 0;
    errors = 0;
    cnt    = 0;
    ev     = 0;
    for (int i = 0; i < 4; i++) begin
      ed[i] = '0;
      eo[i] = 0;
    end

    tbl[0] = '{14'd16383, 16'h8000, 16'h8002, 16'h8002};
    tbl[1] = '{14'd1,     16'd8192, 16'd1,    16'd0};
    tbl[2] = '{14'd1,     16'he000, 16'd0,    16'hffff};
    tbl[3] = '{14'd0,     16'd12345, 16'd0,   16'd0};
    tbl[4] = '{14'd16383, 16'd32767, 16'h7ffd, 16'h7ffd};
    tbl[5] = '{14'd8192,  16'd16384, 16'h2000, 16'h2000};
    tbl[6] = '{14'd1,     16'hffff, 16'd0,    16'hffff};

    reset = 1; ce = 0; din_valid = 1; clr_ovf = 0;
    din0 = 14'd5; din1 = 16'd7;
    step();
    ce = 1;
    step();
    chk("rst_dv", dv_a[0], 0);
    chk("rst_dout", dout_a[0], 0);
    chk("rst_ovf", ovf_a[0], 0);
    reset = 0;
    din_valid = 0;

    for (int i = 0; i < 7; i++) begin
      din0 = tbl[i].a;
      din1 = tbl[i].b;
      din_valid = 1;
      step();
      din_valid = 0;
      step();
      step();
      chk("tbl_dv", dv_a[0], 1);
      chk("tbl_dout0", dout_a[0], tbl[i].x0);
      chk("tbl_dout1", dout_a[1], tbl[i].x1);
      chk("tbl_ovf0", ovf_a[0], 0);
      if (i == 4) begin
        chk("sat_dout2", dout_a[2], 16'h7fff);
        chk("sat_ovf2", ovf_a[2], 1);
      end
    end

    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("clr_ovf2", ovf_a[2], 0);
    din0 = 14'd16383; din1 = 16'd32767; din_valid = 1;
    step();
    din_valid = 0;
    step();
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("setwin_dv2", dv_a[2], 1);
    chk("setwin_ovf2", ovf_a[2], 1);

    din0 = 14'd100; din1 = 16'd200; din_valid = 1;
    step();
    ce = 0;
    din0 = 14'd9999; din1 = 16'd9999;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_dv", dv_a[0], 0);
    end
    ce = 1; din_valid = 0;
    step();
    chk("stall_dv2", dv_a[0], 0);
    step();
    chk("stall_out_dv", dv_a[0], 1);
    chk("stall_out_d", dout_a[0], 16'd1);

    vcount = 0;
    pat = '0;
    for (int s = 0; s < 13; s++) begin
      din_valid = (s < 9) && (s != 4);
      din0 = 14'($urandom);
      din1 = 16'($urandom);
      step();
      pat[s] = dv_a[0];
      if (dv_a[0]) vcount++;
    end
    chk("stream_cnt", vcount, 8);
    chk("stream_pat", pat, 13'h07bc);

    din_valid = 1;
    din0 = 14'd16383; din1 = 16'd32767;
    step();
    din0 = 14'($urandom); din1 = 16'($urandom);
    step();
    reset = 1; din_valid = 0;
    step();
    chk("rst2_dv", dv_a[0], 0);
    chk("rst2_dout", dout_a[0], 0);
    chk("rst2_ovf2", ovf_a[2], 0);
    reset = 0;
    din0 = 14'd16383; din1 = 16'h8000; din_valid = 1;
    step();
    chk("post_dv_a", dv_a[0], 0);
    din_valid = 0;
    step();
    chk("post_dv_b", dv_a[0], 0);
    step();
    chk("post_dv", dv_a[0], 1);
    chk("post_dout", dout_a[0], 16'h8002);

    for (int s = 0; s < 400; s++) begin
      ce        = ($urandom_range(0, 3) != 0);
      din_valid = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      din0      = 14'($urandom);
      din1      = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_window_mul_pipe.md
HAMMING_WINDOW_MUL_PIPE -- requirements
Module: hamming_window_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 14, width of din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 16, width of din1.
REQ-003 SHALL have parameter DIN0_SIGNED, default 0, where 1 means din0 is two's complement and 0 means unsigned.
REQ-004 SHALL have parameter DIN1_SIGNED, default 1, with the same meaning for din1.
REQ-005 SHALL have parameter NUM_STAGE, default 3, legal 1..6, giving pipeline latency in ce-enabled cycles.
REQ-006 SHALL have parameter SHIFT, default 14, legal 0..DIN0_WIDTH+DIN1_WIDTH-1, giving the right shift applied to the product.
REQ-007 SHALL have parameter ROUND, default 1, where 1 means round half up before the shift and 0 means truncate.
REQ-008 SHALL have parameter SAT, default 1, where 1 means saturate to the dout range and 0 means wrap.
REQ-009 SHALL have parameter DOUT_WIDTH, default 16, width of the signed result.
REQ-010 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-011 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-012 SHALL have port ce, input, 1 bit: pipeline advance enable.
REQ-013 SHALL have port din_valid, input, 1 bit: din0/din1 carry a sample this cycle.
REQ-014 SHALL have port din0, input, DIN0_WIDTH: operand 0.
REQ-015 SHALL have port din1, input, DIN1_WIDTH: operand 1.
REQ-016 SHALL have port dout_valid, output, 1 bit: dout holds a new result.
REQ-017 SHALL have port dout, output, DOUT_WIDTH, signed: scaled product.
REQ-018 SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-019 SHALL have port clr_ovf, input, 1 bit: clears ovf.

Function
REQ-020 SHALL extend each operand by one bit (sign extension if signed, zero extension if unsigned) and form an exact signed product of DIN0_WIDTH+DIN1_WIDTH+2 bits.
REQ-021 SHALL, when ROUND=1 and SHIFT>0, add 2^(SHIFT-1) to the product before an arithmetic right shift by SHIFT; otherwise it SHALL apply the arithmetic shift only.
REQ-022 SHALL, when SAT=1, clamp the shifted value to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; when SAT=0, dout SHALL be the low DOUT_WIDTH bits.
REQ-023 SHALL define overflow as the shifted value lying outside the signed DOUT_WIDTH range, evaluated only for valid samples, for both SAT settings.
REQ-024 SHALL register inputs at stage 1; multiply, round, shift and saturate SHALL be distributed over the stages, with dout/dout_valid registered at stage NUM_STAGE.
REQ-025 SHALL advance every data and valid stage only in cycles with ce=1; with ce=0 all stages, dout, dout_valid and ovf SHALL hold.
REQ-026 SHALL, for a sample accepted at edge k (ce=1, din_valid=1), present dout_valid=1 with its result after exactly NUM_STAGE ce=1 edges, counting edge k.
REQ-027 SHALL shift din_valid=0 through as a bubble; dout_valid SHALL be 0 for bubbles, and dout SHALL hold its last valid result.
REQ-028 SHALL accept back-to-back samples at one per ce=1 cycle with no gaps required.
REQ-029 SHALL set ovf when a valid result with overflow is registered at the output stage; ovf SHALL remain set until clr_ovf=1.
REQ-030 SHALL act on clr_ovf regardless of ce; if set and clear occur in the same cycle, ovf SHALL be 1 (set wins).

Reset
REQ-031 SHALL, in a cycle with reset=1, clear all valid stages, dout_valid, dout and ovf to 0 regardless of ce.
REQ-032 SHALL discard in-flight samples on reset, so that no dout_valid is emitted for samples accepted before reset.
REQ-033 SHALL accept a sample presented in the first cycle after reset deasserts.

Verification
REQ-034 SHALL be verified with defaults: din0=16383, din1=-32768 -> dout=-32766, ovf=0, dout_valid exactly 3 ce cycles later.
REQ-035 SHALL be verified with defaults (rounding): din0=1, din1=8192 -> dout=1; din0=1, din1=-8192 -> dout=0; and with ROUND=0, din0=1, din1=8192 -> dout=0.
REQ-036 SHALL be verified with SHIFT=12, SAT=1: din0=16383, din1=32767 -> dout=32767, ovf=1; clr_ovf pulse -> ovf=0; simultaneous overflow and clr_ovf -> ovf=1.
REQ-037 SHALL be verified with a stall: sample accepted, then ce=0 for 5 cycles mid-pipe -> outputs frozen, and the result emerges after the 3rd ce=1 edge.
REQ-038 SHALL be verified with a stream of 8 consecutive valid samples with one bubble inserted -> 8 correct results in order, one dout_valid=0 gap.
REQ-039 SHALL be verified with reset asserted while 2 samples are in flight -> no dout_valid afterwards, dout=0, ovf=0; a new sample presented the next cycle -> correct result after 3 ce cycles.
